btb_2way_param: RTL and testbench
=================================

BTB_2WAY_PARAM -- requirements
Module: btb_2way_param

Interface
REQ-001 SHALL provide parameter SETS, default 256, number of sets; power of two, 2..1024.
REQ-002 SHALL provide parameter INIT_CNT, default 2'b10, counter value written on allocation.
REQ-003 SHALL derive IDX_W = log2(SETS), index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
REQ-004 SHALL have port: i_clk  in  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port: i_reset  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: i_pc  in  32  fetch PC being looked up.
REQ-007 SHALL have port: i_pc_four  in  32  fall-through address (i_pc + 4).
REQ-008 SHALL have port: o_pc_predict  out  32  predicted next PC.
REQ-009 SHALL have port: o_hit  out  1  valid tag match for i_pc.
REQ-010 SHALL have port: o_taken  out  1  hit with counter MSB = 1.
REQ-011 SHALL have port: i_upd_en  in  1  resolved-branch update strobe.
REQ-012 SHALL have port: i_upd_pc  in  32  PC of resolved branch.
REQ-013 SHALL have port: i_upd_target  in  32  resolved branch target.
REQ-014 SHALL have port: i_upd_taken  in  1  resolved direction.
REQ-015 SHALL have port: i_flush  in  1  request to invalidate all entries.
REQ-016 SHALL have port: o_busy  out  1  flush in progress.

Function
REQ-017 SHALL store per set: 2 ways of {valid, tag, 32-bit target, 2-bit counter}, plus 1 LRU bit naming the way to replace.
REQ-018 SHALL perform lookup combinationally: way hits when valid and stored tag equals i_pc tag; both ways never valid with equal tag in one set.
REQ-019 SHALL drive o_pc_predict = hit way target when o_taken, else i_pc_four.
REQ-020 SHALL drive o_hit, o_taken, o_pc_predict from pre-edge state; an update to the same set in the same cycle is not visible until the next cycle.
REQ-021 SHALL, on update hit (i_upd_en, not busy, tag match): write target, saturate counter (+1 if taken, max 11; -1 if not, min 00), set LRU to the other way.
REQ-022 SHALL, on update miss with i_upd_taken = 1: allocate way 0 if invalid, else way 1 if invalid, else the LRU way; write valid = 1, tag, target, counter = INIT_CNT; set LRU to the other way.
REQ-023 SHALL, on update miss with i_upd_taken = 0: change no state.
REQ-024 SHALL implement FSM IDLE/FLUSH: IDLE -> FLUSH on i_flush; FLUSH clears both valid bits of set fl_cnt each cycle, fl_cnt counting 0..SETS-1; FLUSH -> IDLE after set SETS-1 is cleared.
REQ-025 SHALL assert o_busy exactly SETS cycles per flush, starting the cycle after i_flush is sampled.
REQ-026 SHALL, while o_busy = 1: force o_hit = 0, o_taken = 0, o_pc_predict = i_pc_four; drop updates; ignore i_flush.
REQ-027 SHALL, when i_flush and i_upd_en are sampled in the same IDLE cycle, perform the flush and drop the update.
REQ-028 SHALL NOT alter counters, targets or LRU bits during flush.

Reset
REQ-029 SHALL, on i_reset low, immediately clear all valid bits, LRU bits, counters, fl_cnt, and set FSM to IDLE; o_busy = 0, o_hit = 0, o_taken = 0, o_pc_predict = i_pc_four.
REQ-030 SHALL abort an in-progress flush on reset; operation resumes in IDLE on the first edge after i_reset returns high.

Verification (SETS = 256)
REQ-031 SHALL cover cold lookup: after reset, i_pc = 0x100, i_pc_four = 0x104 -> o_hit = 0, o_pc_predict = 0x104.
REQ-032 SHALL cover allocate/train: update 0x100 -> 0x200 taken; lookup 0x100 -> hit, taken, 0x200; two not-taken updates -> counter 00, hit = 1, o_pc_predict = 0x104.
REQ-033 SHALL cover saturation: four taken updates on 0x100 -> counter 11; one not-taken -> counter 10, still predicts 0x200.
REQ-034 SHALL cover replacement: taken updates 0x100, 0x500, then 0x100 again, then 0x900 (all index 0x40) -> 0x500 evicted; 0x100 and 0x900 hit, 0x500 misses.
REQ-035 SHALL cover flush: one-cycle i_flush -> o_busy high exactly 256 cycles; update issued mid-flush dropped; afterwards lookup 0x100 misses.
REQ-036 SHALL cover reset mid-flush: i_reset low at flush cycle 100 -> o_busy drops without waiting for a clock edge; after release, all lookups miss and o_busy = 0.

Source files
------------

// File: rtl/btb_2way_param_if.sv
// Lookup, update and flush signals shared between the BTB and its pipeline client.
interface btb_2way_param_if;
  logic [31:0] i_pc;
  logic [31:0] i_pc_four;
  logic [31:0] o_pc_predict;
  logic        o_hit;
  logic        o_taken;
  logic        i_upd_en;
  logic [31:0] i_upd_pc;
  logic [31:0] i_upd_target;
  logic        i_upd_taken;
  logic        i_flush;
  logic        o_busy;

  modport slave (
    input  i_pc, i_pc_four, i_upd_en, i_upd_pc, i_upd_target, i_upd_taken, i_flush,
    output o_pc_predict, o_hit, o_taken, o_busy
  );

  modport master (
    output i_pc, i_pc_four, i_upd_en, i_upd_pc, i_upd_target, i_upd_taken, i_flush,
    input  o_pc_predict, o_hit, o_taken, o_busy
  );
endinterface

// File: rtl/btb_2way_param.sv
// Two-way set-associative branch target buffer with 2-bit direction counters,
// per-set LRU replacement and a sequential one-set-per-cycle flush engine.
module btb_2way_param #(
  parameter int unsigned SETS     = 256,
  parameter logic [1:0]  INIT_CNT = 2'b10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  btb_2way_param_if.slave    bus
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef enum logic [0:0] {ST_IDLE, ST_FLUSH} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_fl_cnt;
  logic [IDX_W-1:0]   w_fl_cnt_nxt;

  logic [1:0]         r_valid [SETS];
  logic [1:0]         r_cnt   [SETS][2];
  logic [TAG_W-1:0]   r_tag   [SETS][2];
  logic [31:0]        r_tgt   [SETS][2];
  logic [SETS-1:0]    r_lru;

  logic [IDX_W-1:0]   w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic [1:0]         w_lk_hit;
  logic               w_lk_way;
  logic               w_busy;

  logic [IDX_W-1:0]   w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  logic [1:0]         w_up_hit;
  logic               w_up_go;
  logic               w_wr_en;
  logic               w_wr_way;
  logic [1:0]         w_old_cnt;
  logic [1:0]         w_new_cnt;

  assign w_busy   = (r_state == ST_FLUSH);

  // Lookup path: reads pre-edge state only, so a same-cycle update is not forwarded.
  assign w_lk_idx = bus.i_pc[IDX_W+1:2];
  assign w_lk_tag = bus.i_pc[31:IDX_W+2];

  always_comb begin
    for (int unsigned w = 0; w < 2; w++) begin
      w_lk_hit[w] = r_valid[w_lk_idx][w] && (r_tag[w_lk_idx][w] == w_lk_tag);
    end
    w_lk_way = w_lk_hit[1];
  end

  assign bus.o_hit        = (|w_lk_hit) && !w_busy;
  assign bus.o_taken      = bus.o_hit && r_cnt[w_lk_idx][w_lk_way][1];
  assign bus.o_pc_predict = bus.o_taken ? r_tgt[w_lk_idx][w_lk_way] : bus.i_pc_four;
  assign bus.o_busy       = w_busy;

  // Update path: a flush request in the same idle cycle wins over the update.
  assign w_up_idx = bus.i_upd_pc[IDX_W+1:2];
  assign w_up_tag = bus.i_upd_pc[31:IDX_W+2];
  assign w_up_go  = bus.i_upd_en && (r_state == ST_IDLE) && !bus.i_flush;

  always_comb begin
    for (int unsigned w = 0; w < 2; w++) begin
      w_up_hit[w] = r_valid[w_up_idx][w] && (r_tag[w_up_idx][w] == w_up_tag);
    end
    if (|w_up_hit)                  w_wr_way = w_up_hit[1];
    else if (!r_valid[w_up_idx][0]) w_wr_way = 1'b0;
    else if (!r_valid[w_up_idx][1]) w_wr_way = 1'b1;
    else                            w_wr_way = r_lru[w_up_idx];
    w_wr_en   = w_up_go && ((|w_up_hit) || bus.i_upd_taken);
    w_old_cnt = r_cnt[w_up_idx][w_wr_way];
    w_new_cnt = INIT_CNT;
    if (|w_up_hit) begin
      if (bus.i_upd_taken) w_new_cnt = (w_old_cnt == 2'b11) ? w_old_cnt : w_old_cnt + 2'd1;
      else                 w_new_cnt = (w_old_cnt == 2'b00) ? w_old_cnt : w_old_cnt - 2'd1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_fl_cnt_nxt = r_fl_cnt;
    unique case (r_state)
      ST_IDLE: begin
        w_fl_cnt_nxt = '0;
        if (bus.i_flush) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_fl_cnt_nxt = r_fl_cnt + IDX_W'(1);
        if (r_fl_cnt == IDX_W'(SETS - 1)) begin
          w_state_nxt  = ST_IDLE;
          w_fl_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_fl_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= ST_IDLE;
      r_fl_cnt <= '0;
      r_lru    <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        r_valid[s]  <= '0;
        r_cnt[s][0] <= '0;
        r_cnt[s][1] <= '0;
      end
    end else begin
      r_state  <= w_state_nxt;
      r_fl_cnt <= w_fl_cnt_nxt;
      if (r_state == ST_FLUSH) r_valid[r_fl_cnt] <= '0;
      if (w_wr_en) begin
        r_valid[w_up_idx][w_wr_way] <= 1'b1;
        r_cnt[w_up_idx][w_wr_way]   <= w_new_cnt;
        r_lru[w_up_idx]             <= ~w_wr_way;
      end
    end
  end

  // Tag and target arrays are qualified by the valid bits and need no reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_tag[w_up_idx][w_wr_way] <= w_up_tag;
      r_tgt[w_up_idx][w_wr_way] <= bus.i_upd_target;
    end
  end

endmodule

// File: tb/tb_btb_2way_param.sv
// Scoreboard bench for btb_2way_param (SETS = 256): training, saturation,
// replacement, flush timing and asynchronous reset during flush.
module tb_btb_2way_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btb_2way_param_if bus();

  btb_2way_param #(.SETS(256), .INIT_CNT(2'b10)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    logic        hit;
    logic        taken;
    logic [31:0] pred;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq({e.tag, "_hit"},   {31'b0, bus.o_hit},   {31'b0, e.hit});
      check_eq({e.tag, "_taken"}, {31'b0, bus.o_taken}, {31'b0, e.taken});
      check_eq({e.tag, "_pred"},  bus.o_pc_predict,     e.pred);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic hit, input logic tk, input logic [31:0] pred);
    exp_t e;
    bus.i_pc      = pc;
    bus.i_pc_four = pc + 32'd4;
    e.tag = tag; e.hit = hit; e.taken = tk; e.pred = pred;
    sb.push_back(e);
    #1;
    pop_compare();
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    @(negedge clk);
    bus.i_upd_en     = 1'b1;
    bus.i_upd_pc     = pc;
    bus.i_upd_target = tgt;
    bus.i_upd_taken  = tk;
    @(negedge clk);
    bus.i_upd_en     = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int cnt;
  int guard;

  initial begin
    bus.i_pc = '0; bus.i_pc_four = 32'd4;
    bus.i_upd_en = 1'b0; bus.i_upd_pc = '0; bus.i_upd_target = '0;
    bus.i_upd_taken = 1'b0; bus.i_flush = 1'b0;

    #3;
    lookup("in_reset", 32'h100, 1'b0, 1'b0, 32'h104);
    check_eq("in_reset_busy", {31'b0, bus.o_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    lookup("cold", 32'h100, 1'b0, 1'b0, 32'h104);
    check_eq("cold_busy", {31'b0, bus.o_busy}, 32'd0);

    // allocate and train down
    upd(32'h100, 32'h200, 1'b1);
    lookup("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'h200, 1'b0);
    lookup("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 32'h200, 1'b0);
    lookup("nt2", 32'h100, 1'b1, 1'b0, 32'h104);

    // saturate upward from 00
    for (int i = 0; i < 4; i++) upd(32'h100, 32'h200, 1'b1);
    lookup("sat_hi", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'h200, 1'b0);
    lookup("sat_hi_nt", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 32'h200, 1'b0);
    lookup("cnt01", 32'h100, 1'b1, 1'b0, 32'h104);

    // saturate downward: 01 -> 00 -> 00 -> 01
    upd(32'h100, 32'h200, 1'b0);
    upd(32'h100, 32'h200, 1'b0);
    upd(32'h100, 32'h200, 1'b1);
    lookup("sat_lo", 32'h100, 1'b1, 1'b0, 32'h104);

    // replacement in set 0x40
    upd(32'h100, 32'h200, 1'b1);
    upd(32'h500, 32'h600, 1'b1);
    upd(32'h100, 32'h200, 1'b1);
    upd(32'h900, 32'hA00, 1'b1);
    lookup("repl_100", 32'h100, 1'b1, 1'b1, 32'h200);
    lookup("repl_900", 32'h900, 1'b1, 1'b1, 32'hA00);
    lookup("repl_500", 32'h500, 1'b0, 1'b0, 32'h504);

    // not-taken miss leaves everything alone
    upd(32'hD00, 32'hE00, 1'b0);
    lookup("nt_miss", 32'hD00, 1'b0, 1'b0, 32'hD04);
    lookup("nt_miss_100", 32'h100, 1'b1, 1'b1, 32'h200);
    lookup("nt_miss_900", 32'h900, 1'b1, 1'b1, 32'hA00);

    // update becomes visible only after the edge
    @(negedge clk);
    bus.i_upd_en = 1'b1; bus.i_upd_pc = 32'h1104;
    bus.i_upd_target = 32'h1200; bus.i_upd_taken = 1'b1;
    lookup("same_cyc", 32'h1104, 1'b0, 1'b0, 32'h1108);
    @(negedge clk);
    bus.i_upd_en = 1'b0;
    lookup("next_cyc", 32'h1104, 1'b1, 1'b1, 32'h1200);

    // flush with a simultaneous update, mid-flush update and re-flush
    @(negedge clk);
    bus.i_flush = 1'b1;
    bus.i_upd_en = 1'b1; bus.i_upd_pc = 32'h3000;
    bus.i_upd_target = 32'h3100; bus.i_upd_taken = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0; bus.i_upd_en = 1'b0;
    cnt = 0; guard = 0;
    while (guard < 1000) begin
      if (bus.o_busy) cnt++;
      else break;
      bus.i_flush = 1'b0; bus.i_upd_en = 1'b0;
      if (cnt == 10) lookup("flush_forced", 32'h100, 1'b0, 1'b0, 32'h104);
      if (cnt == 50) bus.i_flush = 1'b1;
      if (cnt == 200) begin
        bus.i_upd_en = 1'b1; bus.i_upd_pc = 32'h2000;
        bus.i_upd_target = 32'h2100; bus.i_upd_taken = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    bus.i_flush = 1'b0; bus.i_upd_en = 1'b0;
    check_eq("busy_cycles", cnt, 32'd256);
    lookup("post_flush_100", 32'h100, 1'b0, 1'b0, 32'h104);
    lookup("post_flush_900", 32'h900, 1'b0, 1'b0, 32'h904);
    lookup("post_flush_1104", 32'h1104, 1'b0, 1'b0, 32'h1108);
    lookup("mid_flush_upd", 32'h2000, 1'b0, 1'b0, 32'h2004);
    lookup("flush_start_upd", 32'h3000, 1'b0, 1'b0, 32'h3004);

    // asynchronous reset while flushing
    upd(32'h100, 32'h200, 1'b1);
    lookup("pre_rst", 32'h100, 1'b1, 1'b1, 32'h200);
    @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    cnt = 0; guard = 0;
    while (guard < 1000 && cnt < 100) begin
      if (bus.o_busy) cnt++;
      if (cnt < 100) @(negedge clk);
      guard++;
    end
    check_eq("rst_flush_reached", cnt, 32'd100);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_busy", {31'b0, bus.o_busy}, 32'd0);
    lookup("rst_async", 32'h100, 1'b0, 1'b0, 32'h104);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lookup("post_rst_100", 32'h100, 1'b0, 1'b0, 32'h104);
    lookup("post_rst_1104", 32'h1104, 1'b0, 1'b0, 32'h1108);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.o_busy) cnt++;
    end
    check_eq("post_rst_busy", cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
